// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the single write port of a 1r1w fifo: zero-latency grant, locked while the fifo stalls.
// Define FIFO_ARB_BURST_EN to hold the grant across a burst until req_last_i marks its final beat.
module fifo_wr_arbiter #(
  parameter  int NumReq = 2,
  parameter  int Width  = 32,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq*Width-1:0] req_data_i,
  input  logic [NumReq-1:0]       req_last_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic                    wr_valid_o,
  output logic [IdW+Width-1:0]    wr_data_o,
  input  logic                    wr_ready_i,
  output logic [NumReq-1:0]       grant_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [IdW-1:0]   prio_q, prio_d;
  logic [IdW-1:0]   gnt_q, gnt_d;
  logic [IdW-1:0]   scan_win, winner, winner_inc;
  logic [Width-1:0] payload [NumReq];
  logic             handshake;

  if (NumReq < 2) begin : g_param_chk
    $error("fifo_wr_arbiter: NumReq must be >= 2");
  end

  for (genvar k = 0; k < NumReq; k++) begin : g_payload
    assign payload[k] = req_data_i[k*Width +: Width];
  end

  // Scan from lowest to highest priority so the last hit is the highest-priority requester.
  always_comb begin
    logic [IdW:0] cand;
    scan_win = prio_q;
    cand     = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      cand = {1'b0, prio_q} + (IdW+1)'(i);
      if (cand >= (IdW+1)'(NumReq)) begin
        cand = cand - (IdW+1)'(NumReq);
      end
      if (req_valid_i[cand[IdW-1:0]]) begin
        scan_win = cand[IdW-1:0];
      end
    end
  end

  assign winner     = (state_q == LOCKED) ? gnt_q : scan_win;
  assign winner_inc = (winner == IdW'(NumReq - 1)) ? '0 : winner + IdW'(1);
  assign wr_valid_o = req_valid_i[winner];
  assign wr_data_o  = {winner, payload[winner]};
  assign handshake  = wr_valid_o && wr_ready_i;

  always_comb begin
    for (int k = 0; k < NumReq; k++) begin
      grant_o[k]     = wr_valid_o && (winner == IdW'(k));
      req_ready_o[k] = wr_valid_o && wr_ready_i && (winner == IdW'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    if (handshake) begin
`ifdef FIFO_ARB_BURST_EN
      if (req_last_i[winner]) begin
        state_d = IDLE;
        prio_d  = winner_inc;
      end else begin
        state_d = LOCKED;
        gnt_d   = winner;
      end
`else
      state_d = IDLE;
      prio_d  = winner_inc;
`endif
    end else if (state_q == IDLE && wr_valid_o) begin
      state_d = LOCKED;
      gnt_d   = winner;
    end
  end

`ifndef FIFO_ARB_BURST_EN
  logic unused_last;
  assign unused_last = ^req_last_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
    end
  end

`ifndef FIFO_ARB_BURST_EN
  // A stalled beat is locked; its requester must keep valid up until the fifo accepts it.
  a_hold_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == LOCKED) |-> req_valid_i[gnt_q])
    else $error("fifo_wr_arbiter: locked requester dropped valid");
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-requester and a 3-requester instance.
module tb_fifo_wr_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0]     v4, l4, r4, g4;
  logic [4*W-1:0] d4;
  logic           wv4, wr4;
  logic [2+W-1:0] wd4;

  logic [2:0]     v3, l3, r3, g3;
  logic [3*W-1:0] d3;
  logic           wv3, wr3;
  logic [2+W-1:0] wd3;

  int n_checks = 0;
  int n_errors = 0;
  int beats;

`ifdef FIFO_ARB_BURST_EN
  int exp6 [4] = '{1, 1, 1, 0};
`else
  int exp6 [5] = '{1, 0, 1, 0, 1};
`endif

  fifo_wr_arbiter #(.NumReq(4), .Width(W)) u4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v4), .req_data_i(d4), .req_last_i(l4),
    .req_ready_o(r4), .wr_valid_o(wv4), .wr_data_o(wd4), .wr_ready_i(wr4), .grant_o(g4)
  );

  fifo_wr_arbiter #(.NumReq(3), .Width(W)) u3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_data_i(d3), .req_last_i(l3),
    .req_ready_o(r3), .wr_valid_o(wv3), .wr_data_o(wd3), .wr_ready_i(wr3), .grant_o(g3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check one cycle of the 4-requester instance, then advance past the next edge.
  task automatic cyc4(input string tag, input logic ev, input int id, input logic [3:0] erdy);
    logic [W-1:0] pay;
    @(negedge clk);
    pay = d4[id*W +: W];
    check({tag, "_vld"}, {31'd0, wv4}, {31'd0, ev});
    check({tag, "_gnt"}, {28'd0, g4}, ev ? (32'd1 << id) : 32'd0);
    check({tag, "_rdy"}, {28'd0, r4}, {28'd0, erdy});
    if (ev) check({tag, "_dat"}, {22'd0, wd4}, {22'd0, id[1:0], pay});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc3(input string tag, input logic ev, input int id, input logic [2:0] erdy);
    logic [W-1:0] pay;
    @(negedge clk);
    pay = d3[id*W +: W];
    check({tag, "_vld"}, {31'd0, wv3}, {31'd0, ev});
    check({tag, "_gnt"}, {29'd0, g3}, ev ? (32'd1 << id) : 32'd0);
    check({tag, "_rdy"}, {29'd0, r3}, {29'd0, erdy});
    if (ev) check({tag, "_dat"}, {22'd0, wd3}, {22'd0, id[1:0], pay});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    v4 = '0; l4 = '1; wr4 = 1'b1;
    v3 = '0; l3 = '1; wr3 = 1'b1;
    for (int k = 0; k < 4; k++) d4[k*W +: W] = 8'hA0 + 8'(k);
    for (int k = 0; k < 3; k++) d3[k*W +: W] = 8'hC0 + 8'(k);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset, fifo ready: nothing granted.
    cyc4("t1_u4", 1'b0, 0, 4'b0000);
    cyc3("t1_u3", 1'b0, 0, 3'b000);

    // All requesting: strict rotation 0,1,2,3,0,1,2,3.
    v4 = 4'b1111;
    for (int i = 0; i < 8; i++) cyc4("t2_rr", 1'b1, i % 4, 4'(1 << (i % 4)));

    // Fifo full for three cycles: id0 held, then accepted, then id2.
    v4 = 4'b0101;
    wr4 = 1'b0;
    repeat (3) cyc4("t3_stall", 1'b1, 0, 4'b0000);
    wr4 = 1'b1;
    cyc4("t3_acc", 1'b1, 0, 4'b0001);
    cyc4("t3_next", 1'b1, 2, 4'b0100);

    // Three requesters: winner 2 wraps priority back to 0.
    v3 = 3'b100;
    cyc3("t4_id2", 1'b1, 2, 3'b100);
    v3 = 3'b011;
    cyc3("t4_id0", 1'b1, 0, 3'b001);
    cyc3("t4_id1", 1'b1, 1, 3'b010);
    v3 = 3'b000;
    cyc3("t4_idle", 1'b0, 0, 3'b000);

    // Lock on id3 under backpressure, then reset out of the lock.
    v4 = 4'b1000;
    wr4 = 1'b0;
    cyc4("t5_lock", 1'b1, 3, 4'b0000);
    v4 = 4'b1001;
    cyc4("t5_hold", 1'b1, 3, 4'b0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    v4 = 4'b1010;
    wr4 = 1'b1;
    cyc4("t5_rst", 1'b1, 1, 4'b0010);

    // Single beat from req0 moves priority to 1 before the burst test.
    v4 = 4'b0001;
    cyc4("t6_pre", 1'b1, 0, 4'b0001);

    // req1 sends a 3-beat burst while req0 stays valid.
    beats = 0;
    for (int i = 0; i < $size(exp6); i++) begin
      v4 = {2'b00, (beats < 3), 1'b1};
      l4 = {2'b11, (beats == 2), 1'b1};
      d4[W +: W] = 8'hB0 + 8'(beats);
      cyc4("t6_burst", 1'b1, exp6[i], 4'(1 << exp6[i]));
      if (exp6[i] == 1) beats++;
    end
    v4 = '0;
    l4 = '1;
    cyc4("t6_idle", 1'b0, 0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
